// File: rtl/led_matrix_scan_driver_if.sv
// rtl/led_matrix_scan_driver_if.sv - LED matrix board bundle between the scan driver and the display board
//
// Purpose: groups the frame input and all board-facing outputs of the scan driver.
// Signals:
//   frame       64  cell state, row r in bits [8r+7:8r], column c at bit 8r+c
//   shcp         1  shift-register shift clock
//   stcp         1  shift-register storage (latch) clock
//   mr           1  shift-register master reset, active low
//   oe           1  shift-register output enable, active low
//   ds           1  serial column data
//   rows_out     8  one-hot row enable, active high
//   row_idx      3  row currently latched and displayed
//   frame_done   1  pulse on the last display cycle of row 7
// Modports: master = scan driver side, slave = board/frame-source side.
interface led_matrix_scan_driver_if;
    logic [63:0] frame;
    logic        shcp;
    logic        stcp;
    logic        mr;
    logic        oe;
    logic        ds;
    logic [7:0]  rows_out;
    logic [2:0]  row_idx;
    logic        frame_done;

    modport master (
        input  frame,
        output shcp, stcp, mr, oe, ds, rows_out, row_idx, frame_done
    );

    modport slave (
        output frame,
        input  shcp, stcp, mr, oe, ds, rows_out, row_idx, frame_done
    );
endinterface

// File: rtl/led_matrix_scan_driver.sv
// rtl/led_matrix_scan_driver.sv - 8x8 LED matrix row scanner driving a 74HC595-style column register
//
// Purpose: continuously scans an 8x8 frame one row at a time: shift the row's eight
// column bits out serially, latch them, then light that row for ROW_HOLD cycles.
// The frame is snapshotted only when row 0 is loaded so a frame never tears.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   bus    led_matrix_scan_driver_if.master (frame in; shcp/stcp/mr/oe/ds/rows_out/row_idx/frame_done out)
// All board outputs are registered; they are decoded from the next state so that
// each output value lines up with the state it belongs to.
module led_matrix_scan_driver #(
    parameter int DIV            = 2,
    parameter int ROW_HOLD       = 100,
    parameter bit COL_ACTIVE_LOW = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    led_matrix_scan_driver_if.master      bus
);

    localparam int SHIFT_LEN = 2 * DIV;
    localparam int CNT_MAX   = (ROW_HOLD > SHIFT_LEN) ? ROW_HOLD : SHIFT_LEN;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] DIV_W     = CW'(DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(SHIFT_LEN - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(ROW_HOLD - 1);

    typedef enum logic [2:0] {
        CLEAR,
        LOAD,
        SHIFT,
        LATCH,
        DISPLAY
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [2:0]     row_q, row_d;
    logic [63:0]    shadow_q, shadow_d;

    logic           shcp_q, shcp_d;
    logic           stcp_q, stcp_d;
    logic           mr_q, mr_d;
    logic           oe_q, oe_d;
    logic           ds_q, ds_d;
    logic [7:0]     rows_q, rows_d;
    logic [2:0]     row_idx_q, row_idx_d;
    logic           done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            bit_q     <= '0;
            row_q     <= '0;
            shadow_q  <= '0;
            shcp_q    <= 1'b0;
            stcp_q    <= 1'b0;
            mr_q      <= 1'b0;
            oe_q      <= 1'b1;
            ds_q      <= 1'b0;
            rows_q    <= '0;
            row_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            row_q     <= row_d;
            shadow_q  <= shadow_d;
            shcp_q    <= shcp_d;
            stcp_q    <= stcp_d;
            mr_q      <= mr_d;
            oe_q      <= oe_d;
            ds_q      <= ds_d;
            rows_q    <= rows_d;
            row_idx_q <= row_idx_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        row_d    = row_q;
        shadow_d = shadow_q;

        case (state_q)
            CLEAR: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    row_d   = '0;
                end
            end
            LOAD: begin
                // Only row 0 takes a new snapshot; rows 1-7 reuse it.
                if (row_q == 3'd0) begin
                    shadow_d = bus.frame;
                end
                bit_d   = 3'd7;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd0) begin
                        state_d = LATCH;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            LATCH: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = DISPLAY;
                end
            end
            DISPLAY: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    row_d   = row_q + 3'd1;
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase

        // Output decode for the cycle that begins at the coming edge. oe and
        // rows_out hold through LOAD/SHIFT so the previous row stays lit until
        // the storage register is updated.
        shcp_d    = 1'b0;
        stcp_d    = 1'b0;
        ds_d      = 1'b0;
        mr_d      = 1'b1;
        oe_d      = oe_q;
        rows_d    = rows_q;
        row_idx_d = row_idx_q;
        done_d    = 1'b0;

        case (state_d)
            CLEAR: begin
                mr_d   = 1'b0;
                oe_d   = 1'b1;
                rows_d = '0;
            end
            SHIFT: begin
                // MSB first, so the first bit ends up on Q7 and column c on Qc.
                shcp_d = (cnt_d >= DIV_W);
                ds_d   = shadow_d[{row_d, bit_d}] ^ COL_ACTIVE_LOW;
            end
            LATCH: begin
                stcp_d = (cnt_d < DIV_W);
                oe_d   = 1'b1;
                rows_d = '0;
            end
            DISPLAY: begin
                rows_d    = 8'd1 << row_d;
                row_idx_d = row_d;
                oe_d      = 1'b0;
                done_d    = (row_d == 3'd7) && (cnt_d == HOLD_LAST);
            end
            default: begin
            end
        endcase
    end

    assign bus.shcp       = shcp_q;
    assign bus.stcp       = stcp_q;
    assign bus.mr         = mr_q;
    assign bus.oe         = oe_q;
    assign bus.ds         = ds_q;
    assign bus.rows_out   = rows_q;
    assign bus.row_idx    = row_idx_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// tb/tb_led_matrix_scan_driver.sv - self-checking bench for led_matrix_scan_driver
module tb_led_matrix_scan_driver;

    localparam int D  = 2;
    localparam int RH = 100;
    localparam int P  = 1 + 18 * D + RH;
    localparam int FP = 8 * P;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] frame = '0;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    int          e   = 0;
    bit          mv  = 1'b0;
    logic [63:0] snap = '0;
    logic        prev0 = 1'b0;
    logic        rise0 = 1'b0;

    always #5 clk = ~clk;

    led_matrix_scan_driver_if bus0 ();
    led_matrix_scan_driver_if bus1 ();

    assign bus0.frame = frame;
    assign bus1.frame = frame;

    led_matrix_scan_driver #(.DIV(D), .ROW_HOLD(RH), .COL_ACTIVE_LOW(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.master)
    );

    led_matrix_scan_driver #(.DIV(D), .ROW_HOLD(RH), .COL_ACTIVE_LOW(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    logic [16:0] o0, o1;
    assign o0 = {bus0.shcp, bus0.stcp, bus0.mr, bus0.oe, bus0.ds, bus0.rows_out, bus0.row_idx, bus0.frame_done};
    assign o1 = {bus1.shcp, bus1.stcp, bus1.mr, bus1.oe, bus1.ds, bus1.rows_out, bus1.row_idx, bus1.frame_done};

    // Expected outputs after ee non-reset edges since the last reset edge,
    // derived from the row timeline: CLEAR for D cycles, then rows of length P.
    function automatic logic [16:0] model_out(input int ee, input logic [63:0] sn, input bit cal);
        int j, n, p, row, s, l;
        logic shcp, stcp, mr, oe, ds, done;
        logic [7:0] rows;
        logic [2:0] idx;
        shcp = 0; stcp = 0; mr = 0; oe = 1; ds = 0; done = 0; rows = '0; idx = '0;
        if (ee >= D) begin
            j = ee - D; n = j / P; p = j % P; row = n % 8; mr = 1;
            if (n > 0) begin
                oe = 0; rows = 8'd1 << ((n - 1) % 8); idx = 3'((n - 1) % 8);
            end
            if (p >= 1 && p <= 16 * D) begin
                s = p - 1;
                shcp = ((s % (2 * D)) >= D);
                ds = sn[8 * row + 7 - s / (2 * D)] ^ cal;
            end else if (p > 16 * D && p <= 18 * D) begin
                l = p - 1 - 16 * D;
                stcp = (l < D); oe = 1; rows = '0;
            end else if (p > 18 * D) begin
                rows = 8'd1 << row; idx = 3'(row); oe = 0;
                done = (p == P - 1) && (row == 7);
            end
        end
        return {shcp, stcp, mr, oe, ds, rows, idx, done};
    endfunction

    function automatic int m_n();
        return (e - D) / P;
    endfunction

    function automatic int ph();
        return (e - D) % P;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        prev0 = bus0.shcp;
        @(posedge clk);
        if (reset) begin
            e = 0; snap = '0; mv = 1'b1;
        end else if (mv) begin
            e++;
            if (e >= D && (e - D) % P == 1 && ((e - D) / P) % 8 == 0) snap = frame;
        end
        @(negedge clk);
        cyc++;
        rise0 = bus0.shcp && !prev0;
        if (mv) begin
            chk("out_cal0", 64'(o0), 64'(model_out(e, snap, 1'b0)));
            chk("out_cal1", 64'(o1), 64'(model_out(e, snap, 1'b1)));
        end
    endtask

    initial begin
        int t, t_mr, t_sh, rises, ones0, ones1, g, tgt, last_done, ndone;
        logic [7:0] v0, v1;

        // Reset held 5 cycles, then released; row 0 shifts 0xA5.
        frame = 64'h0000_0000_0000_00A5;
        reset = 1'b1;
        repeat (5) tick();
        chk("reset_mr", 64'(bus0.mr), 0);
        chk("reset_oe", 64'(bus0.oe), 1);
        reset = 1'b0;

        t = 0; t_mr = -1; t_sh = -1; rises = 0; v0 = '0; v1 = '0;
        while (rises < 8 && t < 400) begin
            tick(); t++;
            if (bus0.mr && t_mr < 0) t_mr = t;
            if (rise0) begin
                if (t_sh < 0) t_sh = t;
                v0 = {v0[6:0], bus0.ds};
                v1 = {v1[6:0], bus1.ds};
                rises++;
            end
        end
        chk("mr_rise_delay", 64'(t_mr), 64'(D));
        chk("first_shcp_after_mr", 64'(t_sh - t_mr), 3);
        chk("row0_rises", 64'(rises), 8);
        chk("row0_ds_cal0", 64'(v0), 64'h A5);
        chk("row0_ds_cal1", 64'(v1), 64'h 5A);

        // Free run over two frames; frame changes randomly after the first frame.
        last_done = -1; ndone = 0; ones0 = 0; ones1 = 0;
        for (int i = 0; i < 2 * FP + P; i++) begin
            if (ndone >= 1 && $urandom_range(0, 299) == 0) frame = {$urandom, $urandom};
            tick();
            if (rise0 && m_n() >= 1 && m_n() <= 7) begin
                ones0 += int'(bus0.ds);
                ones1 += int'(bus1.ds);
            end
            if (bus0.frame_done) begin
                chk("done_row_idx", 64'(bus0.row_idx), 7);
                if (last_done >= 0) chk("done_period", 64'(cyc - last_done), 64'(FP));
                last_done = cyc;
                ndone++;
            end
        end
        chk("rows1_7_ones_cal0", 64'(ones0), 0);
        chk("rows1_7_ones_cal1", 64'(ones1), 56);
        chk("done_count", 64'(ndone), 2);

        // All-ones captured, then cleared while row 3 shifts.
        frame = '1;
        g = 0;
        while (!(ph() == 1 && m_n() % 8 == 0) && g < 3 * FP) begin tick(); g++; end
        chk("wait_capture_ones", 64'(g < 3 * FP), 1);
        tgt = $urandom_range(1, 16 * D);
        g = 0;
        while (!(m_n() % 8 == 3 && ph() == tgt) && g < 2 * FP) begin tick(); g++; end
        chk("wait_row3_shift", 64'(g < 2 * FP), 1);
        frame = '0;
        rises = 0; ones0 = 0; g = 0;
        while (!(m_n() % 8 == 0 && ph() == 0) && g < 2 * FP) begin
            tick(); g++;
            if (rise0) begin rises++; ones0 += int'(bus0.ds); end
        end
        chk("rest_of_frame_all_ones", 64'(ones0), 64'(rises));
        chk("rest_of_frame_rises_ge32", 64'(rises >= 32), 1);
        rises = 0; ones0 = 0; ones1 = 0; g = 0;
        while (m_n() % 8 != 1 && g < 2 * P) begin
            tick(); g++;
            if (rise0) begin rises++; ones0 += int'(bus0.ds); ones1 += int'(bus1.ds); end
        end
        chk("new_frame_row0_rises", 64'(rises), 8);
        chk("new_frame_row0_ones_cal0", 64'(ones0), 0);
        chk("new_frame_row0_ones_cal1", 64'(ones1), 8);

        // Reset asserted at random points during the shift of row 5.
        for (int k = 0; k < 3; k++) begin
            frame = {$urandom, $urandom};
            tgt = $urandom_range(1, 16 * D);
            g = 0;
            while (!(e >= D && m_n() % 8 == 5 && ph() == tgt) && g < 2 * FP) begin tick(); g++; end
            chk("wait_row5_shift", 64'(g < 2 * FP), 1);
            reset = 1'b1;
            tick();
            chk("midreset_rows", 64'(bus0.rows_out), 0);
            chk("midreset_oe", 64'(bus0.oe), 1);
            chk("midreset_mr", 64'(bus0.mr), 0);
            chk("midreset_shcp", 64'(bus0.shcp), 0);
            repeat ($urandom_range(0, 3)) tick();
            reset = 1'b0;
            g = 0;
            while (bus0.rows_out == 8'h00 && g < 500) begin tick(); g++; end
            chk("first_rows_after_reset", 64'(bus0.rows_out), 64'h01);
            chk("first_display_cycle", 64'(e), 64'(D + 1 + 18 * D));
            repeat (P) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/led_matrix_scan_driver.md
Name: led_matrix_scan_driver

Overview:
- Downstream display stage of the cellular-automaton game.
- Takes the 64-bit 8x8 cell state and drives the LED matrix board: a 74HC595-style column shift register (ds/shcp/stcp/mr/oe) plus eight one-hot row drivers.
- Scans one row at a time, continuously, and snapshots the frame only at row 0, so a generation update never tears across a displayed frame.

Parameters:
- DIV, 2: shcp/stcp half-period in clk cycles; legal range >= 1.
- ROW_HOLD, 100: clk cycles each row stays lit in DISPLAY; legal range >= 1.
- COL_ACTIVE_LOW, 1: 1 = ds carries the inverted cell bit (cell 1 -> ds 0); 0 = ds carries the cell bit as-is.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- frame  in  64  cell state; row r occupies bits [8r+7:8r], column c is bit 8r+c.
- shcp  out  1  shift-register shift clock.
- stcp  out  1  shift-register storage (latch) clock.
- mr  out  1  shift-register master reset, active low.
- oe  out  1  shift-register output enable, active low.
- ds  out  1  serial column data.
- rows_out  out  8  one-hot row enable, active high; rows_out[r] = row r.
- row_idx  out  3  index of the row currently latched and displayed.
- frame_done  out  1  one-cycle pulse on the last DISPLAY cycle of row 7.

Behaviour:
- Reset (synchronous, active-high) takes precedence over everything, including mid-operation. On the clock edge where reset is sampled 1, the FSM goes to CLEAR and the outputs take:
  - shcp=0, stcp=0, mr=0, oe=1, ds=0
  - rows_out=0, row_idx=0, frame_done=0
  - shadow frame register = 0
- FSM states: CLEAR, LOAD, SHIFT, LATCH, DISPLAY.
- CLEAR:
  - Entered from reset; held while reset=1, then DIV cycles after reset deasserts.
  - mr=0, oe=1 throughout; then mr=1 and go to LOAD with row=0.
- LOAD (1 cycle):
  - If row==0, copy frame into the shadow register.
  - Bit counter=7, go to SHIFT.
  - frame is sampled only here with row==0; changes at any other time affect only the next frame.
- SHIFT (16*DIV cycles): for bit b = 7 down to 0, on shadow bit 8*row+b:
  - ds = bit XOR COL_ACTIVE_LOW;
  - shcp=0 for DIV cycles, then shcp=1 for DIV cycles;
  - ds stays stable for the whole 2*DIV window.
  - The first shifted bit lands at register output Q7, so column c appears on Qc.
  - oe and rows_out keep their previous values: the old row stays lit, because the storage register has not changed yet.
- LATCH (2*DIV cycles):
  - oe=1 and rows_out=0 for the whole state (blanking).
  - stcp=1 for the first DIV cycles, stcp=0 for the last DIV cycles.
  - shcp=0 and ds=0 throughout.
- DISPLAY (ROW_HOLD cycles):
  - rows_out=(1<<row), row_idx=row, oe=0.
  - frame_done=1 on its final cycle when row==7.
  - Then row = row+1 mod 8 (7 wraps to 0) and go to LOAD.
- Timing:
  - Row period = 1 + 18*DIV + ROW_HOLD cycles; with defaults, 137 cycles.
  - Frame period = 8 * row period; with defaults, 1096 cycles.
- Invariants:
  - rows_out is 0 or one-hot, never multi-hot.
  - rows_out!=0 implies oe=0, except during SHIFT, where the previous row stays lit.
  - stcp never rises while shcp=1.
  - The first rows_out value after reset is 8'h01, not a blank frame.
- Simultaneous events: a frame change in the same cycle as LOAD of row 0 is captured, using the value present at that edge.

Test Plan:
1. Reset held 5 cycles, then released -> during reset mr=0, oe=1, rows_out=0, frame_done=0; mr rises exactly DIV=2 cycles after release; first shcp rising edge follows 1 cycle (LOAD) + 2 cycles later.
2. frame=64'h0000_0000_0000_00A5, COL_ACTIVE_LOW=0 -> row 0 ds sequence sampled at the 8 shcp rising edges is 1,0,1,0,0,1,0,1; then one stcp pulse 2 cycles wide; rows_out=8'h01, oe=0 for 100 cycles; rows 1-7 shift all zeros.
3. Same frame, COL_ACTIVE_LOW=1 -> ds sequence 0,1,0,1,1,0,1,0; rows 1-7 shift all ones.
4. Free run over 2 frames -> rows_out cycles 01,02,04,...,80,01; row period 137 cycles; frame_done pulses exactly every 1096 cycles, with row_idx=7 at each pulse.
5. frame changed from all-ones to all-zeros while row 3 is in SHIFT -> rows 3-7 of the current frame still show ones; the new value appears only from the next row 0.
6. Reset asserted mid-SHIFT of row 5 -> the next cycle has the reset values; after release the scan restarts at CLEAR and then row 0.
